// File: rtl/spi_mem_arb_pkg.sv
// Shared types and constants for the two-port SPI memory arbiter.
package spi_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;
  localparam logic       PORT_A        = 1'b0;
  localparam logic       PORT_B        = 1'b1;

endpackage

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter sharing one SPI memory controller between the CPU port (A)
// and the loader/debug port (B); one access in flight, with a response timeout.
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ready,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ready,
  output logic        b_err,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        grant_b
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  arb_state_t  state_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        mask_a_q, mask_b_q;
  logic        grant_b_q;
  logic        m_req_q, m_we_q;
  logic [15:0] m_addr_q;
  logic [7:0]  m_wdata_q;
  logic        a_ready_q, b_ready_q, a_err_q, b_err_q;
  logic [7:0]  a_rdata_q, b_rdata_q;

  logic        req_a_eff, req_b_eff, pick_b, timeout_d;
  logic [7:0]  rsp_data_d;

  always_comb begin
    req_a_eff  = a_req & ~mask_a_q;
    req_b_eff  = b_req & ~mask_b_q;
    // On contention the port that did not win last time takes the grant.
    pick_b     = (req_a_eff & req_b_eff) ? ~grant_b_q : req_b_eff;
    cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    timeout_d  = (cnt_d >= TMO);
    rsp_data_d = m_ready ? (m_we_q ? 8'h00 : m_rdata) : TIMEOUT_RDATA;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      mask_a_q  <= 1'b0;
      mask_b_q  <= 1'b0;
      grant_b_q <= PORT_B;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= 16'h0000;
      m_wdata_q <= 8'h00;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
    end else begin
      m_req_q   <= 1'b0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
      case (state_q)
        IDLE: begin
          mask_a_q <= 1'b0;
          mask_b_q <= 1'b0;
          if (req_a_eff | req_b_eff) begin
            grant_b_q <= pick_b;
            m_we_q    <= pick_b ? b_we    : a_we;
            m_addr_q  <= pick_b ? b_addr  : a_addr;
            m_wdata_q <= pick_b ? b_wdata : a_wdata;
            m_req_q   <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_d;
          // A controller response in the final counted cycle still wins over the timeout.
          if (m_ready || timeout_d) begin
            a_ready_q <= (grant_b_q == PORT_A);
            b_ready_q <= (grant_b_q == PORT_B);
            a_err_q   <= (grant_b_q == PORT_A) & ~m_ready;
            b_err_q   <= (grant_b_q == PORT_B) & ~m_ready;
            a_rdata_q <= (grant_b_q == PORT_A) ? rsp_data_d : 8'h00;
            b_rdata_q <= (grant_b_q == PORT_B) ? rsp_data_d : 8'h00;
            state_q   <= RESP;
          end
        end
        RESP: begin
          mask_a_q <= (grant_b_q == PORT_A);
          mask_b_q <= (grant_b_q == PORT_B);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign a_ready = a_ready_q;
  assign b_ready = b_ready_q;
  assign a_err   = a_err_q;
  assign b_err   = b_err_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != IDLE);
  assign grant_b = grant_b_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Randomized bench for spi_mem_arbiter against a transaction-level arbitration model.
module tb_spi_mem_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_ready, b_ready, a_err, b_err;
  logic        m_req, m_we, m_ready;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic        busy, grant_b;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ready(a_ready), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ready(b_ready), .b_err(b_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .grant_b(grant_b)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t        qa[$], qb[$], ma[$], mb[$];
  logic [63:0] exp_iss[$], act_iss[$], exp_rsp[$], act_rsp[$];
  logic [7:0]  dev_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        last_b  = 1'b1;
  logic        a_rdy_prev = 1'b0, b_rdy_prev = 1'b0, rsp_prev = 1'b0;
  logic        have_cap = 1'b0, scramble = 1'b0, stray = 1'b0;
  logic [24:0] cap;
  int          ctl_at = 0;
  logic        ctl_we;
  logic [15:0] ctl_addr;
  logic [7:0]  ctl_wdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Controller latency in WAIT cycles, derived from the address; 0 = never responds.
  function automatic int lat_of(input logic [15:0] a);
    if (a[15:12] == 4'hF) return 0;
    return (a[2:0] == 3'd7) ? 7 : int'(a[2:0]) + 1;
  endfunction

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [63:0] pack_iss(input int c, input logic p, input logic we,
                                           input logic [15:0] ad, input logic [7:0] wd);
    return {6'd0, 32'(c), p, we, ad, wd};
  endfunction

  function automatic logic [63:0] pack_rsp(input int c, input logic p, input logic e,
                                           input logic [7:0] d);
    return {22'd0, 32'(c), p, e, d};
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a[15:12] == 4'hF) a[15:12] = 4'hE;
    return a;
  endfunction

  task automatic observe();
    int k;
    check_eq("err_wo_rdy", {62'd0, a_err & ~a_ready, b_err & ~b_ready}, 64'd0);
    if (rsp_prev) check_eq("busy_after_rsp", {63'd0, busy}, 64'd0);
    rsp_prev = a_ready | b_ready;
    if (a_ready) act_rsp.push_back(pack_rsp(cyc, 1'b0, a_err, a_rdata));
    if (b_ready) act_rsp.push_back(pack_rsp(cyc, 1'b1, b_err, b_rdata));
    if (m_req) begin
      act_iss.push_back(pack_iss(cyc, grant_b, m_we, m_addr, m_wdata));
      cap       = {m_we, m_addr, m_wdata};
      have_cap  = 1'b1;
      k         = lat_of(m_addr);
      ctl_at    = (k == 0) ? 0 : cyc + k;
      ctl_we    = m_we;
      ctl_addr  = m_addr;
      ctl_wdata = m_wdata;
    end else if (busy && have_cap) begin
      check_eq("m_hold", {39'd0, m_we, m_addr, m_wdata}, {39'd0, cap});
    end
  endtask

  task automatic drive();
    if (a_rdy_prev && qa.size() > 0) qa.delete(0);
    if (b_rdy_prev && qb.size() > 0) qb.delete(0);
    a_rdy_prev = a_ready;
    b_rdy_prev = b_ready;
    if (ctl_at != 0 && cyc == ctl_at) begin
      m_ready = 1'b1;
      m_rdata = ctl_we ? 8'($urandom) : dev_mem[ctl_addr];
      if (ctl_we) dev_mem[ctl_addr] = ctl_wdata;
      ctl_at = 0;
    end else begin
      m_ready = stray;
      m_rdata = 8'($urandom);
    end
    stray = 1'b0;
    if (scramble && busy) begin
      a_req = 1'($urandom); a_we = 1'($urandom); a_addr = 16'($urandom); a_wdata = 8'($urandom);
      b_req = 1'($urandom); b_we = 1'($urandom); b_addr = 16'($urandom); b_wdata = 8'($urandom);
    end else begin
      a_req = (qa.size() > 0);
      b_req = (qb.size() > 0);
      if (qa.size() > 0) begin a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata; end
      else begin a_we = 1'($urandom); a_addr = 16'($urandom); a_wdata = 8'($urandom); end
      if (qb.size() > 0) begin b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata; end
      else begin b_we = 1'($urandom); b_addr = 16'($urandom); b_wdata = 8'($urandom); end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    observe();
    drive();
  endtask

  // Transaction-level prediction: each grant occupies grant+ISSUE+WAIT+RESP, the winner
  // is masked for one IDLE cycle afterwards, and contention alternates between ports.
  task automatic predict(input int s0);
    int          s, m, k, rc;
    logic        ea, eb, pb, err;
    logic [7:0]  d;
    req_t        r;
    s = s0;
    m = -1;
    while (ma.size() > 0 || mb.size() > 0) begin
      ea = (ma.size() > 0) && (m != 0);
      eb = (mb.size() > 0) && (m != 1);
      if (!ea && !eb) begin
        s++;
        m = -1;
      end else begin
        pb  = (ea && eb) ? ~last_b : eb;
        r   = pb ? mb[0] : ma[0];
        k   = lat_of(r.addr);
        err = (k == 0) || (k > TMO);
        rc  = s + 2 + (err ? TMO : k);
        d   = err ? 8'hFF : (r.we ? 8'h00 : ref_mem[r.addr]);
        if (!err && r.we) ref_mem[r.addr] = r.wdata;
        exp_iss.push_back(pack_iss(s + 1, pb, r.we, r.addr, r.wdata));
        exp_rsp.push_back(pack_rsp(rc, pb, err, d));
        last_b = pb;
        m      = pb ? 1 : 0;
        s      = rc + 1;
        if (pb) mb.delete(0); else ma.delete(0);
      end
    end
  endtask

  task automatic run_scn(input string name);
    int budget;
    exp_iss.delete(); exp_rsp.delete(); act_iss.delete(); act_rsp.delete();
    ma = qa;
    mb = qb;
    predict(cyc + 1);
    budget = 0;
    while ((act_rsp.size() < exp_rsp.size() || busy === 1'b1 || qa.size() > 0 || qb.size() > 0)
           && budget < 500) begin
      tick();
      budget++;
    end
    tick();
    tick();
    check_eq({name, "_done"}, 64'(budget < 500), 64'd1);
    check_eq({name, "_n_iss"}, 64'(act_iss.size()), 64'(exp_iss.size()));
    check_eq({name, "_n_rsp"}, 64'(act_rsp.size()), 64'(exp_rsp.size()));
    for (int i = 0; i < exp_iss.size() && i < act_iss.size(); i++)
      check_eq({name, "_iss"}, act_iss[i], exp_iss[i]);
    for (int i = 0; i < exp_rsp.size() && i < act_rsp.size(); i++)
      check_eq({name, "_rsp"}, act_rsp[i], exp_rsp[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq(tag,
      {16'd0, m_req, m_we, m_addr, m_wdata, a_ready, b_ready, a_err, b_err,
       a_rdata, b_rdata, busy, grant_b},
      {16'd0, 1'b0, 1'b0, 16'h0000, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b1});
  endtask

  function automatic req_t mk(input logic we, input logic [15:0] ad, input logic [7:0] wd);
    req_t r;
    r.we = we; r.addr = ad; r.wdata = wd;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] saved_addr;
    int          saved_rsp;
    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = init_val(16'(i));
      ref_mem[i] = init_val(16'(i));
    end
    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 8'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0; b_wdata = 8'h0;
    m_ready = 1'b0; m_rdata = 8'h0;
    repeat (3) tick();
    check_reset_vals("reset_state");
    reset_n = 1'b1;
    tick();
    tick();

    qa.push_back(mk(1'b0, rand_addr(), 8'h00));
    qb.push_back(mk(1'b0, rand_addr(), 8'h00));
    run_scn("contend_first");

    dev_mem[16'h1234] = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    qa.push_back(mk(1'b0, 16'h1234, 8'h00));
    run_scn("single_read");

    qa.push_back(mk(1'b0, rand_addr(), 8'h00));
    qb.push_back(mk(1'b0, rand_addr(), 8'h00));
    run_scn("contend_second");

    qa.push_back(mk(1'b0, 16'h2002, 8'h00));
    qa.push_back(mk(1'b1, 16'h0010, 8'hC3));
    run_scn("held_req");
    qa.push_back(mk(1'b0, 16'h0010, 8'h00));
    run_scn("readback");

    qb.push_back(mk(1'b0, 16'hF123, 8'h00));
    run_scn("timeout");

    saved_addr = m_addr;
    saved_rsp  = act_rsp.size();
    stray = 1'b1;
    tick();
    tick();
    tick();
    check_eq("stray_busy", {63'd0, busy}, 64'd0);
    check_eq("stray_maddr", {48'd0, m_addr}, {48'd0, saved_addr});
    check_eq("stray_rsp", 64'(act_rsp.size()), 64'(saved_rsp));

    scramble = 1'b1;
    qb.push_back(mk(1'b0, 16'h4446, 8'h00));
    run_scn("b_scramble");
    scramble = 1'b0;

    qa.push_back(mk(1'b0, 16'hF000, 8'h00));
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    qa.delete();
    qb.delete();
    ctl_at = 0; have_cap = 1'b0; a_rdy_prev = 1'b0; b_rdy_prev = 1'b0;
    rsp_prev = 1'b0; last_b = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    qa.push_back(mk(1'b0, rand_addr(), 8'h00));
    run_scn("post_reset");

    for (int it = 0; it < 25; it++) begin
      int na, nb;
      scramble = 1'($urandom);
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      for (int j = 0; j < na; j++)
        qa.push_back(mk(1'($urandom),
                        ($urandom_range(0, 5) == 0) ? {4'hF, 12'($urandom)} : rand_addr(),
                        8'($urandom)));
      for (int j = 0; j < nb; j++)
        qb.push_back(mk(1'($urandom),
                        ($urandom_range(0, 5) == 0) ? {4'hF, 12'($urandom)} : rand_addr(),
                        8'($urandom)));
      run_scn("rand");
    end
    scramble = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
# spi_mem_arbiter

Two-port arbiter that shares the single SPI memory controller between the CPU memory port (port A) and the program-loader/debug port (port B). It sits between the requesters and the controller's parallel interface. It grants one access at a time using round-robin, issues the controller's one-shot request, and holds address and data stable for the whole SPI transaction. It returns read data and a one-cycle ready to the granted port, and reports an error if the controller never responds.

## Interface
- TIMEOUT_CYCLES, 255: cycles in WAIT before an access aborts; legal range 2..255.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_req / b_req  in  1  access request; level, held until the port's ready.
- a_we / b_we  in  1  0 = read, 1 = write.
- a_addr / b_addr  in  16  byte address.
- a_wdata / b_wdata  in  8  write data.
- a_rdata / b_rdata  out  8  read data; valid only while the port's ready is high.
- a_ready / b_ready  out  1  one-cycle completion pulse.
- a_err / b_err  out  1  high with ready when the access timed out.
- m_req  out  1  request to the controller; one-cycle pulse.
- m_we  out  1  latched we.
- m_addr  out  16  latched address.
- m_wdata  out  8  latched write data.
- m_rdata  in  8  controller read data.
- m_ready  in  1  controller completion pulse.
- busy  out  1  high in every state except IDLE.
- grant_b  out  1  current or last owner; 0 = A, 1 = B.

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Sample the unmasked requests.
  - If only one port requests, it wins.
  - If both request, the port that did not win last time wins.
  - On a win, latch we/addr/wdata into the m_* registers, set grant_b, and go to ISSUE.
- ISSUE: assert m_req for exactly one cycle, clear the timeout counter, then go to WAIT.
- WAIT:
  - m_req = 0. m_we/m_addr/m_wdata stay held unchanged.
  - Count cycles.
  - If m_ready = 1, capture m_rdata and go to RESP with err = 0.
  - If the counter reaches TIMEOUT_CYCLES, go to RESP with err = 1 and rdata = 8'hFF.
- RESP:
  - Pulse the winner's ready (and err) for one cycle. The loser's outputs stay 0.
  - Set a one-cycle mask on the winner's req for the following IDLE cycle, so a still-high req is not re-granted.
  - Go to IDLE.
- m_ready outside WAIT is ignored.
- Request changes outside IDLE are ignored. The arbiter never aborts a granted access.
- A write returns rdata = 8'h00.
- Reset values:
  - state = IDLE.
  - m_req, m_we, all ready/err outputs and busy = 0.
  - m_addr = 16'h0000; m_wdata, a_rdata and b_rdata = 8'h00.
  - grant_b = 1, so port A wins the first contention.
  - Mask cleared, counter = 0.
- Reset mid-transaction returns the block to IDLE immediately. The controller shares the reset net (inverted), so no partial access survives.

## Timing
- Cycle t: req is high in IDLE.
- t+1: ISSUE, m_req = 1, m_* fields valid. The controller samples the fields one cycle later, and they remain held.
- m_ready seen at cycle w leads to RESP and the port's ready at w+1. End-to-end latency = controller latency + 3 cycles.
- Requesters must drop req, or present a new request, by the cycle after their ready. The mask covers exactly that one cycle.
- Back-to-back accesses from one port: the minimum gap is one IDLE cycle after the mask clears.
- The timeout counter is 8 bits and saturates. It never wraps within a transaction.

## Structure
- Package spi_mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP} in logic [1:0].
  - Constant TIMEOUT_RDATA = 8'hFF.
  - Constant PORT_A = 1'b0, PORT_B = 1'b1.
- Single flat module, no sub-module. The 2-way round-robin pick is a few lines of combinational logic.

## Test plan
- Single read: a_req, a_addr=16'h1234; the controller model returns 8'h5A -> one m_req pulse, m_addr=16'h1234 held until m_ready, a_ready pulse with a_rdata=8'h5A, b_ready stays 0.
- Contention after reset: a_req and b_req rise in the same cycle -> A is served first, then B with no reissue of A; on a second simultaneous request B wins (grant_b=1).
- Held req: a_req held high for 3 cycles after a_ready, requesting a write to 16'h0010 -> exactly one extra access, starting after the masked IDLE cycle; no duplicate read.
- Timeout: TIMEOUT_CYCLES=8, m_ready never asserted -> b_ready=1, b_err=1, b_rdata=8'hFF on cycle 8 of WAIT; busy returns to 0 the next cycle.
- Stray m_ready in IDLE and changes to b_addr during WAIT -> no effect on state or on m_addr.
- reset_n pulsed low during WAIT -> all outputs take their reset values immediately, and a new a_req afterwards completes normally.
